fp_sum_accumulator: RTL and testbench

- Streaming accumulator that sits directly downstream of fp_add_subtract in the softmax datapath.
- Sums a burst of `len` IEEE-754 single-precision values, for example exp(x_i) terms, into one total used as the softmax denominator.
- Instantiates one combinational fp_add_subtract with A = running sum and B = incoming value, and registers its result every accepted beat.

---
 rtl/fp_sum_accumulator.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_sum_accumulator.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fp_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fp_sum_accumulator (with combinational fp_add_subtract)
// Description : Streams a burst of IEEE-754 single values into one running
//               sum for the softmax denominator. The optional overflow flag
//               is built only when FP_ACC_OVF_DETECT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================

module fp_add_subtract (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] y
);
    logic        w_sa, w_sb, w_sl, w_ss;
    logic [7:0]  w_ea, w_eb, w_xa, w_xb, w_xl, w_xs, w_d;
    logic [23:0] w_ma, w_mb, w_ml, w_ms;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [49:0] w_ext, w_shifted;
    logic [26:0] w_big, w_small, w_norm;
    logic [27:0] w_sum;
    logic [4:0]  w_lz, w_shamt;
    logic [8:0]  w_exp_n, w_exp_f;
    logic        w_rup;
    logic [24:0] w_rounded;
    logic [22:0] w_frac;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    always_comb begin
        w_sa    = a[31];
        w_sb    = b[31] ^ sub;
        w_ea    = a[30:23];
        w_eb    = b[30:23];
        w_a_nan = (&w_ea) && (|a[22:0]);
        w_b_nan = (&w_eb) && (|b[22:0]);
        w_a_inf = (&w_ea) && !(|a[22:0]);
        w_b_inf = (&w_eb) && !(|b[22:0]);
        // Subnormals have no hidden bit and share the exponent of 2^-126.
        w_ma    = {|w_ea, a[22:0]};
        w_mb    = {|w_eb, b[22:0]};
        w_xa    = (w_ea == 8'd0) ? 8'd1 : w_ea;
        w_xb    = (w_eb == 8'd0) ? 8'd1 : w_eb;

        if (a[30:0] >= b[30:0]) begin
            w_sl = w_sa; w_xl = w_xa; w_ml = w_ma;
            w_ss = w_sb; w_xs = w_xb; w_ms = w_mb;
        end else begin
            w_sl = w_sb; w_xl = w_xb; w_ml = w_mb;
            w_ss = w_sa; w_xs = w_xa; w_ms = w_ma;
        end

        // Align: 24 mantissa bits, guard, round, then a sticky OR of the rest.
        w_d       = w_xl - w_xs;
        w_ext     = {w_ms, 26'd0};
        w_shifted = w_ext >> w_d;
        w_small   = {w_shifted[49:24], |w_shifted[23:0]};
        w_big     = {w_ml, 3'b000};
        w_sum     = (w_sl == w_ss) ? ({1'b0, w_big} + {1'b0, w_small})
                                   : ({1'b0, w_big} - {1'b0, w_small});

        w_lz    = lzc27(w_sum[26:0]);
        w_shamt = 5'd0;
        if (w_sum[27]) begin
            w_norm  = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp_n = {1'b0, w_xl} + 9'd1;
        end else if ({4'd0, w_lz} < {1'b0, w_xl}) begin
            w_shamt = w_lz;
            w_norm  = w_sum[26:0] << w_shamt;
            w_exp_n = {1'b0, w_xl} - {4'd0, w_lz};
        end else begin
            // Normalising fully would underflow; stop at the subnormal range.
            w_shamt = 5'(w_xl - 8'd1);
            w_norm  = w_sum[26:0] << w_shamt;
            w_exp_n = 9'd0;
        end

        w_rup     = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rounded = {1'b0, w_norm[26:3]} + {24'd0, w_rup};
        if (w_rounded[24]) begin
            w_exp_f = w_exp_n + 9'd1;
            w_frac  = w_rounded[23:1];
        end else if (w_exp_n == 9'd0 && w_rounded[23]) begin
            w_exp_f = 9'd1;
            w_frac  = w_rounded[22:0];
        end else begin
            w_exp_f = w_exp_n;
            w_frac  = w_rounded[22:0];
        end

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
            y = 32'h7FC0_0000;
        else if (w_a_inf)
            y = {w_sa, 8'hFF, 23'd0};
        else if (w_b_inf)
            y = {w_sb, 8'hFF, 23'd0};
        else if (w_sum == 28'd0)
            y = {w_sl & w_ss, 31'd0};
        else if (w_exp_f >= 9'd255)
            y = {w_sl, 8'hFF, 23'd0};
        else
            y = {w_sl, w_exp_f[7:0], w_frac};
    end
endmodule

module fp_sum_accumulator #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   sum_valid,
    output logic [DATA_WIDTH-1:0]  sum_data,
    output logic                   busy,
    output logic                   ovf
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [DATA_WIDTH-1:0]  r_acc;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0]  r_sum_data;
    logic                   r_sum_valid;
    logic                   r_in_ready;
    logic                   r_busy;
    logic [DATA_WIDTH-1:0]  w_add;
    logic                   w_beat;

    fp_add_subtract u_add (
        .a   (r_acc),
        .b   (in_data),
        .sub (1'b0),
        .y   (w_add)
    );

    // r_in_ready is high exactly while in ACCUM.
    assign w_beat = in_valid && r_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sum_data  <= '0;
            r_sum_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_busy <= 1'b1;
                        if (len != '0) begin
                            r_cnt      <= len;
                            r_in_ready <= 1'b1;
                            r_state    <= S_ACCUM;
                        end else begin
                            r_cnt       <= '0;
                            r_sum_data  <= '0;
                            r_sum_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc <= w_add;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == COUNT_WIDTH'(1)) begin
                            r_in_ready  <= 1'b0;
                            r_sum_data  <= w_add;
                            r_sum_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FP_ACC_OVF_DETECT_EN
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (r_state == S_IDLE && start)
            r_ovf <= 1'b0;
        else if (w_beat && (&w_add[30:23]))
            r_ovf <= 1'b1;
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign sum_valid = r_sum_valid;
    assign sum_data  = r_sum_data;
    assign busy      = r_busy;
endmodule

`default_nettype wire

// File: tb/tb_fp_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_sum_accumulator
// Description : Directed bench for fp_sum_accumulator bursts, stalls, resets.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_fp_sum_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        sum_valid;
    logic [31:0] sum_data;
    logic        busy;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

`ifdef FP_ACC_OVF_DETECT_EN
    localparam logic c_ovf_exp = 1'b1;
`else
    localparam logic c_ovf_exp = 1'b0;
`endif

    fp_sum_accumulator #(.DATA_WIDTH(32), .COUNT_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sum_valid (sum_valid),
        .sum_data  (sum_data),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic sv, input logic rdy, input logic bsy);
        chk({tag, ".sum_valid"}, {31'd0, sum_valid}, {31'd0, sv});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, rdy});
        chk({tag, ".busy"},      {31'd0, busy},      {31'd0, bsy});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 32'd0;
        tick(); tick();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.sum_data", sum_data, 32'h0);
        chk("reset.ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        tick();

        // len=2: 2.0 + 3.0
        start = 1'b1; len = 8'd2; tick(); start = 1'b0;
        chk_ctl("t1.accum", 1'b0, 1'b1, 1'b1);
        in_valid = 1'b1; in_data = 32'h4000_0000; tick();
        in_data = 32'h4040_0000; tick(); in_valid = 1'b0;
        chk_ctl("t1.done", 1'b1, 1'b0, 1'b1);
        chk("t1.sum", sum_data, 32'h40A0_0000);
        tick();
        chk_ctl("t1.idle", 1'b0, 1'b0, 1'b0);
        chk("t1.hold", sum_data, 32'h40A0_0000);

        // len=4 of 1.0 with a two-cycle stall after beat 2
        start = 1'b1; len = 8'd4; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h3F80_0000; tick(); tick();
        in_valid = 1'b0; tick(); tick();
        chk_ctl("t2.stall", 1'b0, 1'b1, 1'b1);
        in_valid = 1'b1; tick(); tick(); in_valid = 1'b0;
        chk_ctl("t2.done", 1'b1, 1'b0, 1'b1);
        chk("t2.sum", sum_data, 32'h4080_0000);
        tick();
        chk_ctl("t2.single_pulse", 1'b0, 1'b0, 1'b0);

        // len=0 while data is offered
        start = 1'b1; len = 8'd0; in_valid = 1'b1; in_data = 32'h4000_0000; tick(); start = 1'b0;
        chk_ctl("t3.done", 1'b1, 1'b0, 1'b1);
        chk("t3.sum", sum_data, 32'h0);
        tick();
        chk_ctl("t3.idle", 1'b0, 1'b0, 1'b0);
        tick();
        chk_ctl("t3.idle2", 1'b0, 1'b0, 1'b0);
        chk("t3.hold", sum_data, 32'h0);
        in_valid = 1'b0;

        // mid-burst reset, then a fresh len=1 burst
        start = 1'b1; len = 8'd3; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h4000_0000; tick(); in_valid = 1'b0;
        rst = 1'b1; #2;
        chk_ctl("t4.async", 1'b0, 1'b0, 1'b0);
        tick(); rst = 1'b0; tick();
        chk_ctl("t4.after", 1'b0, 1'b0, 1'b0);
        chk("t4.sum_rst", sum_data, 32'h0);
        start = 1'b1; len = 8'd1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h4040_0000; tick(); in_valid = 1'b0;
        chk_ctl("t4.done", 1'b1, 1'b0, 1'b1);
        chk("t4.sum", sum_data, 32'h4040_0000);
        tick();

        // start re-pulsed during ACCUM and DONE is ignored
        start = 1'b1; len = 8'd2; tick();
        len = 8'd5; in_valid = 1'b1; in_data = 32'h3F80_0000; tick();
        tick(); in_valid = 1'b0;
        chk_ctl("t5.done", 1'b1, 1'b0, 1'b1);
        chk("t5.sum", sum_data, 32'h4000_0000);
        tick(); start = 1'b0;
        chk_ctl("t5.idle", 1'b0, 1'b0, 1'b0);
        tick();

        // mixed signs: 3.0 + (-2.0)
        start = 1'b1; len = 8'd2; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h4040_0000; tick();
        in_data = 32'hC000_0000; tick(); in_valid = 1'b0;
        chk("t6.sum", sum_data, 32'h3F80_0000);
        tick();

        // overflow to +Inf
        start = 1'b1; len = 8'd2; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h7F7F_FFFF; tick(); tick(); in_valid = 1'b0;
        chk("t7.sum", sum_data, 32'h7F80_0000);
        chk("t7.ovf_done", {31'd0, ovf}, {31'd0, c_ovf_exp});
        tick(); tick();
        chk("t7.ovf_idle", {31'd0, ovf}, {31'd0, c_ovf_exp});
        start = 1'b1; len = 8'd1; tick(); start = 1'b0;
        chk("t7.ovf_clear", {31'd0, ovf}, 32'd0);
        in_valid = 1'b1; in_data = 32'h3F80_0000; tick(); in_valid = 1'b0;
        chk("t7.sum_after", sum_data, 32'h3F80_0000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
